vend_ctrl: RTL and testbench

- Sequencer for the drink-vending datapath.
- Takes raw coin pulses from the 0.5 and 1.0 coin slots and accumulates credit in half-unit steps.
- Issues a dispense handshake once credit reaches the price, then returns change one half-unit coin at a time over a separate handshake.
- Sits between the coin acceptor and the dispenser/change hopper; owns all credit state.

---
 rtl/vend_ctrl_if.sv | 50 +++++
 rtl/vend_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_vend_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vend_ctrl_if.sv
// -----------------------------------------------------------------------------
// vend_ctrl_if
// Groups the coin, dispense and change handshake signals of the vending
// sequencer.
//   master : the sequencer side. It receives the coin pulses, cancel and the
//            two acknowledges. It drives vend_req, chg_req, credit, coin_block
//            and busy.
//   slave  : the environment side (coin acceptor, dispenser, change hopper).
// Parameter CW : width of the credit bus, in half-units.
// -----------------------------------------------------------------------------
interface vend_ctrl_if #(
  parameter int CW = 4
);
  logic          coin_half;
  logic          coin_one;
  logic          cancel;
  logic          vend_req;
  logic          vend_ack;
  logic          chg_req;
  logic          chg_ack;
  logic [CW-1:0] credit;
  logic          coin_block;
  logic          busy;

  modport master (
    input  coin_half,
    input  coin_one,
    input  cancel,
    input  vend_ack,
    input  chg_ack,
    output vend_req,
    output chg_req,
    output credit,
    output coin_block,
    output busy
  );

  modport slave (
    output coin_half,
    output coin_one,
    output cancel,
    output vend_ack,
    output chg_ack,
    input  vend_req,
    input  chg_req,
    input  credit,
    input  coin_block,
    input  busy
  );
endinterface

// File: rtl/vend_ctrl.sv
// -----------------------------------------------------------------------------
// vend_ctrl
// Sequencer for the drink-vending datapath. It accumulates coin credit in
// half-unit steps. Once the credit reaches the price, it requests a dispense.
// It then pays back any excess, or refunds the full credit on cancel or on an
// idle timeout. Change is paid one half-unit coin per acknowledged cycle.
//
// Ports:
//   sys_clk            : system clock, rising edge
//   rst_n              : asynchronous active-low reset
//   bus (master)       : coin_half, coin_one, cancel, vend_ack and chg_ack
//                        are inputs. vend_req, chg_req, credit, coin_block
//                        and busy are outputs.
//   vend_cnt, refund_cnt (16 bit): these ports exist only when the macro
//                        VEND_CTRL_STATS_EN is defined. vend_cnt counts
//                        completed vends. refund_cnt counts cancel/timeout
//                        refunds. Both counters wrap.
//
// Parameters:
//   PRICE_HALVES : price in half-units, 1..12
//   TIMEOUT_CYC  : idle cycles in COLLECT before an automatic refund, >= 2
//   CW           : credit width. It must hold PRICE_HALVES+2 and be >= 2.
// -----------------------------------------------------------------------------
module vend_ctrl #(
  parameter int PRICE_HALVES = 5,
  parameter int TIMEOUT_CYC  = 50000000,
  parameter int CW           = 4
) (
  input  logic              sys_clk,
  input  logic              rst_n,
`ifdef VEND_CTRL_STATS_EN
  output logic [15:0]       vend_cnt,
  output logic [15:0]       refund_cnt,
`endif
  vend_ctrl_if.master       bus
);

  localparam int            TW       = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] PRICE_C  = CW'(PRICE_HALVES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [CW-1:0] credit_r;
  logic [CW-1:0] credit_s;
  logic [TW-1:0] tmo_r;
  logic [TW-1:0] tmo_s;
  logic [CW-1:0] sum_s;
  logic          coin_any_s;
  logic          refund_s;
  logic          vend_done_s;
  logic          vend_req_r;
  logic          chg_req_r;
  logic          coin_block_r;
  logic          busy_r;

  // Credit after adding this cycle's coins (a 1.0 coin is worth two halves).
  assign sum_s      = credit_r
                    + {{(CW-1){1'b0}}, bus.coin_half}
                    + {{(CW-2){1'b0}}, bus.coin_one, 1'b0};
  assign coin_any_s = bus.coin_half | bus.coin_one;

  // Next-state, next-credit and timeout-counter decode.
  always_comb begin
    state_s     = state_r;
    credit_s    = credit_r;
    tmo_s       = {TW{1'b0}};
    refund_s    = 1'b0;
    vend_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // In IDLE, cancel is ignored even when a coin arrives in the same cycle.
        credit_s = sum_s;
        if (sum_s >= PRICE_C) begin
          state_s = ST_VEND;
        end else if (sum_s != {CW{1'b0}}) begin
          state_s = ST_COLLECT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        credit_s = sum_s;
        if (coin_any_s) begin
          // The coin is added first; reaching the price overrides a cancel.
          if (sum_s >= PRICE_C) begin
            state_s = ST_VEND;
          end else if (bus.cancel) begin
            state_s  = ST_CHANGE;
            refund_s = 1'b1;
          end else begin
            state_s = ST_COLLECT;
          end
        end else if (bus.cancel || (tmo_r == TMO_LAST)) begin
          state_s  = ST_CHANGE;
          refund_s = 1'b1;
        end else begin
          tmo_s = tmo_r + TW'(1);
        end
      end
      ST_VEND: begin
        if (bus.vend_ack) begin
          vend_done_s = 1'b1;
          credit_s    = credit_r - PRICE_C;
          if (credit_r > PRICE_C) begin
            state_s = ST_CHANGE;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_VEND;
        end
      end
      ST_CHANGE: begin
        if (bus.chg_ack) begin
          credit_s = credit_r - CW'(1);
          if (credit_r == CW'(1)) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_CHANGE;
          end
        end else begin
          state_s = ST_CHANGE;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        credit_s = {CW{1'b0}};
      end
    endcase
  end

  // State, credit and timeout registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      credit_r <= {CW{1'b0}};
      tmo_r    <= {TW{1'b0}};
    end else begin
      state_r  <= state_s;
      credit_r <= credit_s;
      tmo_r    <= tmo_s;
    end
  end

  // Output flags are registered from the next state, so they track state_r exactly.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      vend_req_r   <= 1'b0;
      chg_req_r    <= 1'b0;
      coin_block_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      vend_req_r   <= (state_s == ST_VEND);
      chg_req_r    <= (state_s == ST_CHANGE);
      coin_block_r <= (state_s == ST_VEND) || (state_s == ST_CHANGE);
      busy_r       <= (state_s != ST_IDLE);
    end
  end

  assign bus.vend_req   = vend_req_r;
  assign bus.chg_req    = chg_req_r;
  assign bus.coin_block = coin_block_r;
  assign bus.busy       = busy_r;
  assign bus.credit     = credit_r;

`ifdef VEND_CTRL_STATS_EN
  logic [15:0] vend_cnt_r;
  logic [15:0] refund_cnt_r;

  // Usage counters; the 16-bit increment wraps 65535 -> 0 naturally.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      vend_cnt_r   <= 16'd0;
      refund_cnt_r <= 16'd0;
    end else begin
      if (vend_done_s) begin
        vend_cnt_r <= vend_cnt_r + 16'd1;
      end
      if (refund_s) begin
        refund_cnt_r <= refund_cnt_r + 16'd1;
      end
    end
  end

  assign vend_cnt   = vend_cnt_r;
  assign refund_cnt = refund_cnt_r;
`endif

endmodule

// File: tb/tb_vend_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vend_ctrl
// Self-checking bench for vend_ctrl, built with PRICE_HALVES=5 and
// TIMEOUT_CYC=8. It runs three phases:
//   - a directed vector table,
//   - hand-written timeout and async-reset sequences,
//   - random stimulus checked against a credit/obligation reference model.
// -----------------------------------------------------------------------------
module tb_vend_ctrl;

  localparam int PRICE = 5;
  localparam int TMO   = 8;
  localparam int CW    = 4;

  logic sys_clk;
  logic rst_n;

  vend_ctrl_if #(.CW(CW)) bus ();

`ifdef VEND_CTRL_STATS_EN
  logic [15:0] vend_cnt;
  logic [15:0] refund_cnt;
`endif

  vend_ctrl #(
    .PRICE_HALVES (PRICE),
    .TIMEOUT_CYC  (TMO),
    .CW           (CW)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
`ifdef VEND_CTRL_STATS_EN
    .vend_cnt   (vend_cnt),
    .refund_cnt (refund_cnt),
`endif
    .bus        (bus.master)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic h, o, c, va, ca;
    int   cr;
    logic vr, chr, cb, bz;
  } vec_t;

  vec_t vecs[$];

  // Reference model: credit plus two pending obligations, "dispense owed"
  // and "change owed". A machine with nothing owed is collecting whenever
  // its credit is nonzero.
  int m_credit, m_idle, m_vends, m_refunds;
  bit m_wait, m_pay;

  task automatic add(input logic h, o, c, va, ca, input int cr,
                     input logic vr, chr, cb, bz);
    vec_t v;
    v.h = h; v.o = o; v.c = c; v.va = va; v.ca = ca;
    v.cr = cr; v.vr = vr; v.chr = chr; v.cb = cb; v.bz = bz;
    vecs.push_back(v);
  endtask

  task automatic step(input logic h, o, c, va, ca);
    bus.coin_half = h;
    bus.coin_one  = o;
    bus.cancel    = c;
    bus.vend_ack  = va;
    bus.chg_ack   = ca;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input int cr,
                       input logic vr, chr, cb, bz);
    n_cmp++;
    if (bus.credit !== CW'(cr) || bus.vend_req !== vr || bus.chg_req !== chr ||
        bus.coin_block !== cb || bus.busy !== bz) begin
      n_err++;
      $display("FAIL %s: got credit=%0d vend_req=%b chg_req=%b coin_block=%b busy=%b, want credit=%0d vend_req=%b chg_req=%b coin_block=%b busy=%b",
               name, bus.credit, bus.vend_req, bus.chg_req, bus.coin_block, bus.busy,
               cr, vr, chr, cb, bz);
    end
  endtask

  task automatic do_reset();
    bus.coin_half = 1'b0; bus.coin_one = 1'b0; bus.cancel = 1'b0;
    bus.vend_ack = 1'b0;  bus.chg_ack = 1'b0;
    rst_n = 1'b0;
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    check("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic model_step(input bit h, o, c, va, ca);
    int  coins;
    bit  was_collect;
    if (m_wait) begin
      if (va) begin
        m_credit -= PRICE;
        m_vends++;
        m_wait = 1'b0;
        m_pay  = (m_credit > 0);
      end
    end else if (m_pay) begin
      if (ca) begin
        m_credit--;
        if (m_credit == 0) m_pay = 1'b0;
      end
    end else begin
      was_collect = (m_credit > 0);
      coins = int'(h) + 2 * int'(o);
      if (coins > 0) begin
        m_credit += coins;
        m_idle = 0;
        if (m_credit >= PRICE) m_wait = 1'b1;
        else if (c && was_collect) begin
          m_pay = 1'b1;
          m_refunds++;
        end
      end else if (was_collect) begin
        if (c || m_idle == TMO - 1) begin
          m_pay  = 1'b1;
          m_idle = 0;
          m_refunds++;
        end else begin
          m_idle++;
        end
      end
    end
    if (m_wait || m_pay || m_credit == 0) m_idle = 0;
  endtask

  initial begin
    do_reset();

    // Columns: coin_half, coin_one, cancel, vend_ack, chg_ack -> credit, vend_req, chg_req, coin_block, busy.
    // Exact price.
    add(0,1,0,0,0, 2, 0,0,0,1);
    add(0,1,0,0,0, 4, 0,0,0,1);
    add(1,0,0,0,0, 5, 1,0,1,1);
    add(0,0,0,0,0, 5, 1,0,1,1);
    add(0,0,0,1,0, 0, 0,0,0,0);
    add(0,0,0,0,0, 0, 0,0,0,0);
    // Overpay with change.
    add(0,1,0,0,0, 2, 0,0,0,1);
    add(0,1,0,0,0, 4, 0,0,0,1);
    add(1,1,0,0,0, 7, 1,0,1,1);
    add(0,0,0,1,0, 2, 0,1,1,1);
    add(0,0,0,0,1, 1, 0,1,1,1);
    add(0,0,0,0,1, 0, 0,0,0,0);
    // Cancel together with a coin.
    add(0,1,0,0,0, 2, 0,0,0,1);
    add(1,0,0,0,0, 3, 0,0,0,1);
    add(0,1,1,0,0, 5, 1,0,1,1);
    add(0,0,0,1,0, 0, 0,0,0,0);
    add(1,0,0,0,0, 1, 0,0,0,1);
    add(0,1,1,0,0, 3, 0,1,1,1);
    add(0,0,0,0,1, 2, 0,1,1,1);
    add(1,0,0,0,0, 2, 0,1,1,1);
    add(0,0,0,0,1, 1, 0,1,1,1);
    add(0,0,0,0,1, 0, 0,0,0,0);
    // Cancel refund with chg_ack on every other cycle.
    add(0,1,0,0,0, 2, 0,0,0,1);
    add(0,0,1,0,0, 2, 0,1,1,1);
    add(0,0,0,0,1, 1, 0,1,1,1);
    add(0,0,0,0,0, 1, 0,1,1,1);
    add(0,0,0,0,1, 0, 0,0,0,0);
    // Acks and cancel while idle have no effect.
    add(0,0,1,1,1, 0, 0,0,0,0);

    foreach (vecs[i]) begin
      step(vecs[i].h, vecs[i].o, vecs[i].c, vecs[i].va, vecs[i].ca);
      check($sformatf("vec%0d", i), vecs[i].cr, vecs[i].vr, vecs[i].chr,
            vecs[i].cb, vecs[i].bz);
    end

    // Timeout: CHANGE is entered exactly TMO edges after the coin edge.
    step(1,0,0,0,0);
    for (int k = 1; k < TMO; k++) begin
      step(0,0,0,0,0);
      check($sformatf("tmo_wait%0d", k), 1, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    step(0,0,0,0,0);
    check("tmo_fire", 1, 1'b0, 1'b1, 1'b1, 1'b1);
    step(0,0,0,0,1);
    check("tmo_paid", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // A coin arriving at count 6 restarts the timeout count.
    step(1,0,0,0,0);
    for (int k = 0; k < 6; k++) step(0,0,0,0,0);
    step(1,0,0,0,0);
    check("tmo_restart", 2, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k < TMO; k++) step(0,0,0,0,0);
    check("tmo_restart_wait", 2, 1'b0, 1'b0, 1'b0, 1'b1);
    step(0,0,0,0,0);
    check("tmo_restart_fire", 2, 1'b0, 1'b1, 1'b1, 1'b1);
    step(0,0,0,0,1);
    step(0,0,0,0,1);
    check("tmo_restart_paid", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Async reset while vend_req is held.
    step(0,1,0,0,0);
    step(0,1,0,0,0);
    step(0,1,0,0,0);
    step(0,0,0,0,0);
    check("pre_rst_vend", 6, 1'b1, 1'b0, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    step(1,0,0,0,0);
    check("post_rst_coin", 1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Random stimulus against the reference model.
    do_reset();
    m_credit = 0; m_idle = 0; m_vends = 0; m_refunds = 0;
    m_wait = 1'b0; m_pay = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      bit h, o, c, va, ca;
      h  = ($urandom_range(0, 7) == 0);
      o  = ($urandom_range(0, 7) == 0);
      c  = ($urandom_range(0, 39) == 0);
      va = ($urandom_range(0, 2) == 0);
      ca = ($urandom_range(0, 1) == 0);
      step(h, o, c, va, ca);
      model_step(h, o, c, va, ca);
      check($sformatf("rand%0d", n), m_credit, m_wait, m_pay,
            m_wait | m_pay, m_wait | m_pay | (m_credit > 0));
    end
`ifdef VEND_CTRL_STATS_EN
    n_cmp++;
    if (vend_cnt !== 16'(m_vends) || refund_cnt !== 16'(m_refunds)) begin
      n_err++;
      $display("FAIL stats: got vend_cnt=%0d refund_cnt=%0d, want %0d %0d",
               vend_cnt, refund_cnt, m_vends, m_refunds);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
